// File: rtl/gpu_ram_pkg.sv
// Shared constants and types for the GPU local-RAM block-transfer engine.
package gpu_ram_pkg;

    localparam int GPU_RAM_AW     = 10;
    localparam int GPU_RAM_DW     = 32;
    localparam int GPU_RAM_RD_LAT = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DUMP = 2'd2;
    localparam state_t ST_FIN  = 2'd3;

    typedef enum logic {
        DIR_LOAD = 1'b0,
        DIR_DUMP = 1'b1
    } dir_e;

endpackage

// File: rtl/gpu_ram_dma_fifo2.sv
// Two-entry fall-through FIFO used as the dump-path skid buffer.
// Latency: a pushed word is visible at the head in the push cycle when empty.
// Backpressure: none internally; the caller never pushes into a full FIFO without popping.
module gpu_ram_dma_fifo2
    import gpu_ram_pkg::*;
#(
    parameter int DW = GPU_RAM_DW
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic          vld,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          empty;
    logic          store;
    logic          take;

    assign empty = (count == 2'd0);
    assign take  = pop && !empty;
    // A word popped in the same cycle it arrives into an empty FIFO never needs storing.
    assign store = push && !(pop && empty);
    assign vld   = !empty || push;
    assign head  = empty ? push_dat : mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= !wr_ptr;
            end
            if (take) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + {1'b0, store} - {1'b0, take};
        end
    end

endmodule

// File: rtl/gpu_ram_dma.sv
// Block-transfer initiator: loads a word stream into GPU RAM or dumps RAM out as a stream.
// Latency: load writes in the handshake cycle; dump data appears 2 cycles after command accept.
// Backpressure: in_ready follows ram_gnt; dump reads stall when the 2-deep skid would overflow.
module gpu_ram_dma
    import gpu_ram_pkg::*;
#(
    parameter int AW = GPU_RAM_AW,
    parameter int DW = GPU_RAM_DW
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_dir,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          ram_gnt,
    output logic [AW-1:0] ram_addr,
    output logic          ramen,
    output logic          gpu_memw,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] SKID_DEPTH = 3'(GPU_RAM_RD_LAT + 1);

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   remain;
    logic [AW:0]   issue_left;
    logic          rd_inflight;

    logic          live;
    logic          load_beat;
    logic          rd_issue;
    logic          out_pop;
    logic          fifo_vld;
    logic [DW-1:0] fifo_head;
    logic [1:0]    fifo_count;
    logic [2:0]    occupancy;
    logic [2:0]    occ_limit;

    // Outputs are gated during reset so nothing leaks before the first reset edge.
    assign live      = !reset;
    assign load_beat = live && (state == ST_LOAD) && ram_gnt && in_valid;

    assign out_valid = live && fifo_vld;
    assign out_data  = out_valid ? fifo_head : '0;
    assign out_pop   = out_valid && out_ready;

    // A slot freed by this cycle's pop can be refilled, keeping one word per cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_inflight};
    assign occ_limit = SKID_DEPTH + {2'b00, out_pop};
    assign rd_issue  = live && (state == ST_DUMP) && ram_gnt &&
                       (issue_left != '0) && (occupancy < occ_limit);

    assign cmd_ready = live && (state == ST_IDLE);
    assign in_ready  = live && (state == ST_LOAD) && ram_gnt;
    assign ramen     = load_beat || rd_issue;
    assign gpu_memw  = load_beat;
    assign ram_addr  = ramen ? cur_addr : '0;
    assign ram_wdata = load_beat ? in_data : '0;
    assign busy      = live && (state != ST_IDLE);
    assign done      = live && (state == ST_FIN);

    gpu_ram_dma_fifo2 #(
        .DW(DW)
    ) u_skid (
        .sys_clk (sys_clk),
        .reset   (reset),
        .push    (rd_inflight),
        .push_dat(ram_rdata),
        .pop     (out_pop),
        .vld     (fifo_vld),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_addr    <= '0;
            remain      <= '0;
            issue_left  <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr   <= cmd_addr;
                        remain     <= cmd_len;
                        issue_left <= cmd_len;
                        if (cmd_len == '0) begin
                            state <= ST_FIN;
                        end else if (cmd_dir == DIR_DUMP) begin
                            state <= ST_DUMP;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_beat) begin
                        cur_addr <= cur_addr + AW'(1);
                        remain   <= remain - (AW+1)'(1);
                        if (remain == (AW+1)'(1)) begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_DUMP: begin
                    if (rd_issue) begin
                        cur_addr   <= cur_addr + AW'(1);
                        issue_left <= issue_left - (AW+1)'(1);
                    end
                    if (out_pop) begin
                        remain <= remain - (AW+1)'(1);
                        if (remain == (AW+1)'(1)) begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
